// File: rtl/dmem_port.sv
// dmem_port: single-clock word memory behind a valid/ready request port.
// Sub-word loads/stores (B/H/W/BU/HU), a base-address window with range
// checks, and optional splitting of word-crossing accesses into two beats.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqValid/reqReady        request handshake (accept on valid && ready)
//   reqWe, reqAddr, reqWdata request fields (store data right-aligned)
//   reqMemOp                 0=B 1=H 2=W 4=BU 5=HU
//   rspValid                 one-cycle completion pulse
//   rspRdata, rspErr         registered result, held between responses
module dmem_port #(
  parameter int                   addrWidth       = 32,
  parameter int                   depth           = 131072,
  parameter logic [addrWidth-1:0] baseAddr        = 'h8000_0000,
  parameter bit                   allowMisaligned = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWe,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [31:0]          reqWdata,
  input  logic [2:0]           reqMemOp,
  output logic                 rspValid,
  output logic [31:0]          rspRdata,
  output logic                 rspErr
);

  localparam int AW = $clog2(depth);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state_q, state_d;

  // latched request
  logic          we_q;
  logic [2:0]    op_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic          split_q;

  logic [31:0]   w0_q;     // first beat of a split load
  logic [31:0]   ram_q;    // synchronous read register
  logic [31:0]   rdata_q;
  logic          rerr_q;

  logic [31:0]   mem [depth];

  // ---------------- accept-time decode ----------------
  logic [addrWidth-1:0] a_diff, a_widx;
  logic [1:0]           a_off;
  logic                 a_cross, a_illegal, a_range, a_err;

  always_comb begin
    a_diff    = reqAddr - baseAddr;
    a_widx    = a_diff >> 2;
    a_off     = reqAddr[1:0];
    a_cross   = (reqMemOp[1:0] == 2'd1 && a_off == 2'd3) ||
                (reqMemOp[1:0] == 2'd2 && a_off != 2'd0);
    a_illegal = (reqMemOp[1:0] == 2'd3) || (reqMemOp == 3'd6) ||
                (reqWe && reqMemOp[2]);
    // a_diff wraps when below the base, so the lower-bound test is separate
    a_range   = (reqAddr < baseAddr) ||
                (a_widx >= addrWidth'(depth)) ||
                (a_cross && a_widx == addrWidth'(depth - 1));
    a_err     = a_illegal || a_range || (a_cross && !allowMisaligned);
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    reqReady = 1'b0;
    rspValid = 1'b0;
    unique case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) state_d = ACC0;
      end
      ACC0: state_d = (split_q && !err_q) ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: begin
        rspValid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- store lane steering ----------------
  logic [3:0]  smask;
  logic [7:0]  m8;
  logic [63:0] d64;

  always_comb begin
    unique case (op_q[1:0])
      2'd0:    smask = 4'b0001;
      2'd1:    smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
    // low half feeds beat 0 (word idx), high half beat 1 (word idx+1)
    m8  = {4'b0000, smask} << off_q;
    d64 = {32'h0, wdata_q} << {off_q, 3'b000};
  end

  // ---------------- storage port ----------------
  // The read for word idx is issued on the accept edge straight from the
  // request, so ACC0 already holds word0 and the formatted result can be
  // registered into rspRdata on the way into RESP. Loads use ACC0 to read
  // idx+1; stores use ACC0/ACC1 to write idx / idx+1.
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;

  always_comb begin
    mem_addr = a_widx[AW-1:0];
    mem_we   = 1'b0;
    mem_be   = m8[3:0];
    mem_wd   = d64[31:0];
    unique case (state_q)
      ACC0: begin
        mem_addr = we_q ? idx_q : idx_q + AW'(1);
        mem_we   = we_q && !err_q;
      end
      ACC1: begin
        mem_addr = idx_q + AW'(1);
        mem_we   = we_q;
        mem_be   = m8[7:4];
        mem_wd   = d64[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end
    ram_q <= mem[mem_addr];
  end

  // ---------------- load formatting ----------------
  logic [31:0] lw0, raw, ext, rsp_d;

  always_comb begin
    // split loads: word0 was parked in w0_q, word1 is in ram_q
    lw0 = (state_q == ACC1) ? w0_q : ram_q;
    raw = 32'({ram_q, lw0} >> {off_q, 3'b000});
    unique case (op_q)
      3'd0:    ext = {{24{raw[7]}},  raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ext = {24'h0, raw[7:0]};
      3'd5:    ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
    rsp_d = (err_q || we_q) ? 32'h0 : ext;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      w0_q    <= 32'h0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && reqValid) begin
        we_q    <= reqWe;
        op_q    <= reqMemOp;
        off_q   <= a_off;
        idx_q   <= a_widx[AW-1:0];
        wdata_q <= reqWdata;
        err_q   <= a_err;
        split_q <= a_cross;
      end
      if (state_q == ACC0) w0_q <= ram_q;
      if (state_d == RESP) begin
        rdata_q <= rsp_d;
        rerr_q  <= err_q;
      end
    end
  end

  assign rspRdata = rdata_q;
  assign rspErr   = rerr_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: instance A splits misaligned accesses,
// instance B rejects them. Both share request fields, separate valids.
module tb_dmem_port;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        vA, vB, we;
  logic [31:0] addr, wd;
  logic [2:0]  op;
  logic        rdyA, rvA, errA, rdyB, rvB, errB;
  logic [31:0] rdA, rdB;

  int n_run = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_port #(.addrWidth(32), .depth(DEPTH), .baseAddr(BASE), .allowMisaligned(1'b1)) dutA (
    .clk(clk), .rst(rst), .reqValid(vA), .reqReady(rdyA), .reqWe(we), .reqAddr(addr),
    .reqWdata(wd), .reqMemOp(op), .rspValid(rvA), .rspRdata(rdA), .rspErr(errA));

  dmem_port #(.addrWidth(32), .depth(DEPTH), .baseAddr(BASE), .allowMisaligned(1'b0)) dutB (
    .clk(clk), .rst(rst), .reqValid(vB), .reqReady(rdyB), .reqWe(we), .reqAddr(addr),
    .reqWdata(wd), .reqMemOp(op), .rspValid(rvB), .rspRdata(rdB), .rspErr(errB));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request on instance s (0=A, 1=B); lat is the response cycle relative
  // to the accept cycle T (T+2 single beat, T+3 split).
  task automatic req(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] o, output logic [31:0] rd, output logic er, output int lat);
    int  n;
    bit  got;
    n = 0;
    @(negedge clk);
    while (!(s ? rdyB : rdyA) && n < 10) begin @(negedge clk); n++; end
    we = w; addr = a; wd = d; op = o;
    if (s) vB = 1'b1; else vA = 1'b1;
    @(posedge clk); #1;
    vA = 1'b0; vB = 1'b0;
    got = 1'b0; n = 0; rd = 32'h0; er = 1'b0; lat = 0;
    while (!got && n < 8) begin
      @(posedge clk); #1; n++;
      if (s ? rvB : rvA) begin
        got = 1'b1; rd = s ? rdB : rdA; er = s ? errB : errA; lat = n + 1;
      end
    end
    if (!got) chk("rsp_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic ld(input bit s, input logic [31:0] a, input logic [2:0] o,
                    input logic [31:0] exp, input int elat, input string t);
    logic [31:0] rd; logic er; int lat;
    req(s, 1'b0, a, 32'h0, o, rd, er, lat);
    chk({t, "_rd"}, rd, exp);
    chk({t, "_err"}, er, 32'h0);
    chk({t, "_lat"}, lat, elat);
  endtask

  task automatic st(input bit s, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] o, input int elat, input string t);
    logic [31:0] rd; logic er; int lat;
    req(s, 1'b1, a, d, o, rd, er, lat);
    chk({t, "_rd"}, rd, 32'h0);
    chk({t, "_err"}, er, 32'h0);
    chk({t, "_lat"}, lat, elat);
  endtask

  task automatic bad(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] o, input string t);
    logic [31:0] rd; logic er; int lat;
    req(s, w, a, d, o, rd, er, lat);
    chk({t, "_rd"}, rd, 32'h0);
    chk({t, "_err"}, er, 32'h1);
    chk({t, "_lat"}, lat, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc[3];
    int nacc;
    bit seen;

    rst = 1'b1; vA = 1'b0; vB = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readyA", rdyA, 32'h1);
    chk("rst_rvalidA", rvA, 32'h0);
    chk("rst_rdataA", rdA, 32'h0);
    chk("rst_errA", errA, 32'h0);
    chk("rst_readyB", rdyB, 32'h1);
    @(negedge clk) rst = 1'b0;

    // aligned store and sub-word loads
    st(0, BASE,        32'hDEADBEEF, 3'd2, 2, "stW0");
    ld(0, BASE,        3'd2, 32'hDEADBEEF, 2, "ldW0");
    ld(0, BASE + 1,    3'd0, 32'hFFFFFFBE, 2, "ldB1");
    ld(0, BASE + 3,    3'd4, 32'h000000DE, 2, "ldBU3");
    ld(0, BASE + 2,    3'd1, 32'hFFFFDEAD, 2, "ldH2");

    // split store / loads on instance A
    st(0, BASE + 4,    32'hAAAAAAAA, 3'd2, 2, "stW1");
    st(0, BASE + 8,    32'hBBBBBBBB, 3'd2, 2, "stW2");
    st(0, BASE + 6,    32'h11223344, 3'd2, 3, "stSplit");
    ld(0, BASE + 4,    3'd2, 32'h3344AAAA, 2, "ldW1");
    ld(0, BASE + 8,    3'd2, 32'hBBBB1122, 2, "ldW2");
    ld(0, BASE + 6,    3'd2, 32'h11223344, 3, "ldSplitW");
    ld(0, BASE + 3,    3'd1, 32'hFFFFAADE, 3, "ldSplitH");

    // address window
    bad(0, 1'b0, 32'h7FFFFFFC, 32'h0, 3'd2, "ldBelow");
    st(0, BASE + 4*DEPTH - 4, 32'hCAFEF00D, 3'd2, 2, "stLast");
    bad(0, 1'b1, BASE + 4*DEPTH, 32'h55555555, 3'd2, "stAbove");
    ld(0, BASE,        3'd2, 32'hDEADBEEF, 2, "ldW0_afterAbove");
    bad(0, 1'b1, BASE + 4*DEPTH - 2, 32'h66666666, 3'd2, "stSplitLast");
    ld(0, BASE + 4*DEPTH - 4, 3'd2, 32'hCAFEF00D, 2, "ldLast");

    // illegal encodings
    bad(0, 1'b0, BASE, 32'h0, 3'd3, "ldOp3");
    bad(0, 1'b1, BASE, 32'h12345678, 3'd4, "stOp4");
    ld(0, BASE,        3'd2, 32'hDEADBEEF, 2, "ldW0_afterOp4");

    // instance B: misaligned accesses rejected
    st(1, BASE,        32'h01020304, 3'd2, 2, "BstW0");
    st(1, BASE + 4,    32'h05060708, 3'd2, 2, "BstW1");
    ld(1, BASE + 2,    3'd5, 32'h00000102, 2, "BldHU2");
    bad(1, 1'b0, BASE + 3, 32'h0, 3'd1, "BldH3");
    bad(1, 1'b1, BASE + 3, 32'h0000FFFF, 3'd1, "BstH3");
    ld(1, BASE,        3'd2, 32'h01020304, 2, "BldW0");
    ld(1, BASE + 4,    3'd2, 32'h05060708, 2, "BldW1");

    // back-to-back: valid held high, accept spacing
    nacc = 0;
    @(negedge clk);
    while (!rdyA) @(negedge clk);
    we = 1'b0; addr = BASE; op = 3'd2; vA = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (rdyA && nacc < 3) begin acc[nacc] = cyc; nacc++; end
      @(negedge clk);
    end
    vA = 1'b0;
    chk("b2b_count", nacc, 3);
    chk("b2b_gap01", acc[1] - acc[0], 3);
    chk("b2b_gap12", acc[2] - acc[1], 3);

    // reset during ACC1 of a split store
    st(0, BASE + 12,   32'h33333333, 3'd2, 2, "stW3");
    st(0, BASE + 16,   32'h44444444, 3'd2, 2, "stW4");
    ld(0, BASE + 12,   3'd2, 32'h33333333, 2, "ldW3pre");
    @(negedge clk);
    while (!rdyA) @(negedge clk);
    we = 1'b1; addr = BASE + 14; wd = 32'hA1B2C3D4; op = 3'd2; vA = 1'b1;
    @(posedge clk); #1 vA = 1'b0;   // accepted, now ACC0
    @(posedge clk); #2 rst = 1'b1;  // now ACC1, beat 0 written
    seen = 1'b0;
    #1 seen = seen | rvA;
    chk("rstAcc1_ready", rdyA, 32'h1);
    chk("rstAcc1_rdata", rdA, 32'h0);
    chk("rstAcc1_err", errA, 32'h0);
    repeat (2) begin @(posedge clk); #1 seen = seen | rvA; end
    @(negedge clk) rst = 1'b0;
    repeat (4) begin @(posedge clk); #1 seen = seen | rvA; end
    chk("rstAcc1_noRsp", {31'h0, seen}, 32'h0);
    ld(0, BASE + 12,   3'd2, 32'hC3D43333, 2, "ldW3post");
    ld(0, BASE + 16,   3'd2, 32'h44444444, 2, "ldW4post");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
